// File: rtl/comparator_digit_serial.sv
// Digit-serial signed/unsigned comparator: scans two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, and reports LT/LE/EQ/NE plus three-way flags over valid/ready.
module comparator_digit_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N + 1);

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("comparator_digit_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_acc_q, eq_acc_d;
  logic             lt_acc_q, lt_acc_d;
  logic [DIGIT-1:0] a_dig, b_dig;

  // Operands are shifted left each scan cycle, so the current digit is always on top.
  assign a_dig = a_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    eq_acc_d = eq_acc_q;
    lt_acc_d = lt_acc_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Flipping the sign bits maps two's-complement order onto unsigned order.
          a_d      = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
          b_d      = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
          op_d     = op;
          eq_acc_d = 1'b1;
          lt_acc_d = 1'b0;
          cnt_d    = '0;
          state_d  = StScan;
        end
      end
      StScan: begin
        if (eq_acc_q) begin
          if (a_dig < b_dig) begin
            lt_acc_d = 1'b1;
            eq_acc_d = 1'b0;
          end else if (a_dig > b_dig) begin
            eq_acc_d = 1'b0;
          end
        end
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      eq_acc_q <= 1'b0;
      lt_acc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      eq_acc_q <= eq_acc_d;
      lt_acc_q <= lt_acc_d;
    end
  end

  // Flags are gated by DONE so nothing stale is visible outside a valid result.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    lt        = out_valid & lt_acc_q;
    eq        = out_valid & eq_acc_q;
    gt        = out_valid & ~lt_acc_q & ~eq_acc_q;
    result    = 1'b0;
    case (op_q)
      2'b00:   result = lt;
      2'b01:   result = lt | eq;
      2'b10:   result = eq;
      2'b11:   result = out_valid & ~eq;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_comparator_digit_serial.sv
// Scoreboard bench for comparator_digit_serial: one DUT with DIGIT=4 (N=8), one with
// DIGIT=32 (N=1); expected flags come from a behavioural compare model.
module tb_comparator_digit_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        sgn;
  logic        sel;
  logic [31:0] a, b;
  logic [1:0]  op;

  logic in_valid0, in_ready0, out_valid0, result0, lt0, eq0, gt0;
  logic in_valid1, in_ready1, out_valid1, result1, lt1, eq1, gt1;
  logic cur_ready, cur_valid;
  logic [3:0] cur_flags;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  assign in_valid0 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;

  always_comb begin
    cur_ready = sel ? in_ready1 : in_ready0;
    cur_valid = sel ? out_valid1 : out_valid0;
    cur_flags = sel ? {result1, lt1, eq1, gt1} : {result0, lt0, eq0, gt0};
  end

  comparator_digit_serial #(.WIDTH(32), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .a(a), .b(b),
    .op(op), .sgn(sgn), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .lt(lt0), .eq(eq0), .gt(gt0)
  );

  comparator_digit_serial #(.WIDTH(32), .DIGIT(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .a(a), .b(b),
    .op(op), .sgn(sgn), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .lt(lt1), .eq(eq1), .gt(gt1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {result, lt, eq, gt}.
  function automatic logic [3:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                       input logic [1:0] mop, input logic msgn);
    logic l, e, g, r;
    e = (ma == mb);
    l = msgn ? ($signed(ma) < $signed(mb)) : (ma < mb);
    g = ~l & ~e;
    case (mop)
      2'b00:   r = l;
      2'b01:   r = l | e;
      2'b10:   r = e;
      default: r = ~e;
    endcase
    return {r, l, e, g};
  endfunction

  // Called #1 after a rising edge; returns at the same phase.
  task automatic run_req(input logic s, input logic [31:0] ta, input logic [31:0] tb2,
                         input logic [1:0] top, input logic tsgn, input int hold,
                         input int n_exp, input string tag);
    int         lat;
    logic [3:0] exp;
    sel = s;
    check_eq({tag, "_ready_idle"}, 32'(cur_ready), 32'd1);
    a = ta; b = tb2; op = top; sgn = tsgn; in_valid = 1'b1;
    exp_q.push_back(model(ta, tb2, top, tsgn));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom); sgn = 1'($urandom);
    lat = 0;
    while (!cur_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(n_exp));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
      exp = 4'h0;
    end else begin
      exp = exp_q.pop_front();
    end
    repeat (hold) begin
      check_eq({tag, "_hold_flags"}, 32'(cur_flags), 32'(exp));
      check_eq({tag, "_hold_ready"}, 32'(cur_ready), 32'd0);
      @(posedge clk); #1;
    end
    check_eq({tag, "_flags"}, 32'(cur_flags), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_valid_clr"}, 32'(cur_valid), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(cur_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
    a = '0; b = '0; op = '0; sgn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(in_ready0), 32'd1);
    check_eq("rst_valid", 32'(out_valid0), 32'd0);
    check_eq("rst_flags", 32'({result0, lt0, eq0, gt0}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1'b0, 0, 8, "t1");
    run_req(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1'b1, 0, 8, "t2");
    run_req(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 8, "t3_eq");
    run_req(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b01, 1'b0, 0, 8, "t3_le");
    run_req(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 1'b0, 0, 8, "t3_ne");
    run_req(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 1'b0, 0, 8, "t4_u");
    run_req(1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 1'b1, 0, 8, "t4_s");
    run_req(1'b0, 32'h1234_5678, 32'h1234_5679, 2'b01, 1'b0, 5, 8, "t5");

    // Abort mid-scan: accept, then reset during the third scan cycle.
    sel = 1'b0; a = 32'd1; b = 32'd2; op = 2'b00; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t6_ready", 32'(in_ready0), 32'd1);
    check_eq("t6_valid", 32'(out_valid0), 32'd0);
    check_eq("t6_flags", 32'({result0, lt0, eq0, gt0}), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | out_valid0;
    end
    check_eq("t6_no_stale", 32'(seen), 32'd0);
    run_req(1'b0, 32'd5, 32'd5, 2'b01, 1'b0, 0, 8, "t6_new");

    run_req(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1'b0, 0, 1, "t6_n1");
    run_req(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 1'b1, 2, 1, "t6_n1s");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? (ra ^ (32'd1 << $urandom_range(3, 0))) : 32'($urandom);
      if (i % 5 == 0) rb = ra;
      run_req(1'((i % 4) == 0), ra, rb, 2'($urandom), 1'($urandom), i % 2,
              ((i % 4) == 0) ? 1 : 8, "rnd");
    end

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
